jtag_tap_param: RTL and testbench
=================================

Name: jtag_tap_param

Overview:
- Parametrised successor to the fixed 2-bit-IR JTAG top.
- Contains the full 16-state TAP controller, an IR_WIDTH-bit instruction register, instruction decode, bypass register and optional 32-bit IDCODE register.
- Routes shift, capture and update strobes to NUM_CHAINS external data-register chains (BSR, internal scan, ...) and muxes their serial outputs onto TDO.
- Sits between chip JTAG pins and core-specific scan/boundary chains.

Parameters:
- IR_WIDTH, 4: instruction register width, minimum 2.
- NUM_CHAINS, 2: number of external DR chains, 1..2**IR_WIDTH-3.
- IDCODE_VAL, 32'h0000_0001: IDCODE register contents; bit0 must be 1.
- IDCODE_OP, 2**IR_WIDTH-2: IDCODE opcode.

Ports:
- CK  in  1  single clock; all state changes on rising edge.
- TRST  in  1  synchronous, active-high reset.
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out; 0 when not shifting.
- chain_tdi  out  1  equals TDI, fanned out to every chain.
- chain_tdo  in  NUM_CHAINS  serial outputs of the external chains.
- chain_sel  out  NUM_CHAINS  one-hot chain selected by current instruction; all zero for BYPASS/IDCODE.
- chain_capture  out  NUM_CHAINS  chain_sel AND (state==CAPTURE_DR).
- chain_shift  out  NUM_CHAINS  chain_sel AND (state==SHIFT_DR).
- chain_update  out  NUM_CHAINS  chain_sel AND (state==UPDATE_DR).
- tap_state  out  4  current TAP state encoding, for debug.

Behaviour:
- Clock and reset are fixed: one clock (CK); reset TRST is synchronous, active-high. On a CK edge with TRST=1: state=TEST_LOGIC_RESET, IR=reset instruction, bypass=0, IDCODE shift reg=IDCODE_VAL. TRST overrides TMS and any operation in progress, including mid-shift.
- TAP FSM follows IEEE 1149.1 TMS transitions across all 16 states: TLR, RTI, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, plus the _IR equivalents.
- Five consecutive TMS=1 edges reach TLR from any state. In TLR the IR is forced to the reset instruction every cycle.
- Actions occur on the CK edge that ends a cycle spent in the named state:
  - CAPTURE_IR: IR shift reg loads {0...0,01}.
  - SHIFT_IR: IR shift reg shifts right, TDI enters MSB.
  - UPDATE_IR: IR latch loads from the shift reg.
  - CAPTURE_DR: bypass loads 0; IDCODE shift reg loads IDCODE_VAL.
  - SHIFT_DR: bypass loads TDI; IDCODE shift reg shifts right with TDI into bit31.
- Selected-DR latency: bypass gives TDI to TDO after 1 shift; IDCODE after 32 shifts.
- Decode of the IR latch:
  - 0 or all-ones: BYPASS.
  - IDCODE_OP: IDCODE.
  - 1..NUM_CHAINS: chain (opcode-1).
  - Any other opcode: BYPASS.
- Reset instruction: IDCODE when the feature is enabled, otherwise BYPASS.
- TDO is combinational and is 0 outside SHIFT_IR/SHIFT_DR:
  - SHIFT_IR: IR shift reg bit0.
  - SHIFT_DR: bit0 of the selected register — bypass, IDCODE bit0, or chain_tdo[k].
- chain_sel changes only on UPDATE_IR or reset, never mid-DR-scan.

Optional Feature:
- Macro: JTAG_IDCODE_EN.
- When defined:
  - IDCODE register is present.
  - IDCODE_OP decodes to IDCODE.
  - Reset instruction is IDCODE.
- When undefined:
  - No IDCODE register.
  - IDCODE_OP decodes as BYPASS.
  - Reset instruction is BYPASS, so the DR path after reset is 1 bit long.

Decomposition:
- Package jtag_pkg holds:
  - tap_state_t enum with the 4-bit encodings (TLR=4'hF, RTI=4'hC, SHIFT_DR=4'h2, SHIFT_IR=4'hA, etc., per 1149.1 Table).
  - IR_CAPTURE_LSBS=2'b01.
  - Decode-result enum (DEC_BYPASS, DEC_IDCODE, DEC_CHAIN).
- Sub-module jtag_tap_fsm: the 16-state controller with inputs CK, TRST, TMS and output tap_state.
- Top-level holds IR, decode, bypass, IDCODE and the TDO mux.

Test Plan:
- Reset via TMS: from SHIFT_DR, TMS=1 for 5 edges -> tap_state=TLR, chain_sel=0; a 6th TMS=1 stays in TLR.
- IDCODE read (JTAG_IDCODE_EN, IDCODE_VAL=32'h1234_5677):
  - Stimulus: TRST=1 for 1 cycle, then TMS 0,1,0,0 to reach SHIFT_DR, then 32 shifts.
  - Response: TDO yields 0x12345677 LSB first.
- IR capture and BYPASS:
  - Stimulus: shift IR_WIDTH=4 bits of TDI=1 in SHIFT_IR.
  - Response: TDO shows 1,0,0,0. After UPDATE_IR, opcode 4'hF is BYPASS; TDI pattern 1,0,1 appears on TDO one cycle later.
- Chain select (opcode 2, NUM_CHAINS=2):
  - Response: chain_sel=2'b10; chain_capture[1] pulses 1 cycle in CAPTURE_DR; chain_shift[1] high in SHIFT_DR; TDO=chain_tdo[1]; chain_update[1] pulses in UPDATE_DR; bits [0] stay 0.
- Illegal opcode: load 4'h7 with NUM_CHAINS=2 -> decodes BYPASS, chain_sel=0.
- TRST mid-operation:
  - Stimulus: assert TRST during the 10th IDCODE shift.
  - Response: next edge gives TLR; IR=IDCODE (or BYPASS without the macro); TDO=0.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the parametrised JTAG TAP.
//   tap_state_t     : 4-bit TAP controller state, IEEE 1149.1 encodings
//   IR_CAPTURE_LSBS : fixed pattern loaded into the IR shift register in CAPTURE_IR
//   dec_t           : result of decoding the latched instruction
// Optional feature macro used by the files importing this package: JTAG_IDCODE_EN.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  typedef enum logic [1:0] {
    DEC_BYPASS = 2'd0,
    DEC_IDCODE = 2'd1,
    DEC_CHAIN  = 2'd2
  } dec_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: the 16-state IEEE 1149.1 TAP controller.
// Ports:
//   CK        in  clock, state advances on the rising edge
//   TRST      in  synchronous active-high reset to TEST_LOGIC_RESET
//   TMS       in  TAP mode select
//   tap_state out current state (registered), also used as the debug view
// Five consecutive TMS=1 edges reach TEST_LOGIC_RESET from any state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       CK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t tap_state
);

  always_ff @(posedge CK) begin
    if (TRST) begin
      tap_state <= TEST_LOGIC_RESET;
    end else begin
      case (tap_state)
        TEST_LOGIC_RESET: tap_state <= TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    tap_state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_DR:        tap_state <= TMS ? SELECT_IR        : CAPTURE_DR;
        CAPTURE_DR:       tap_state <= TMS ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         tap_state <= TMS ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         tap_state <= TMS ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         tap_state <= TMS ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         tap_state <= TMS ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        tap_state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_IR:        tap_state <= TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       tap_state <= TMS ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         tap_state <= TMS ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         tap_state <= TMS ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         tap_state <= TMS ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         tap_state <= TMS ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        tap_state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        default:          tap_state <= TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised JTAG TAP with IR_WIDTH-bit instruction register,
// bypass register, optional 32-bit IDCODE register and NUM_CHAINS external
// data-register chains.
// Optional feature: define JTAG_IDCODE_EN to include the IDCODE register, decode
// IDCODE_OP as IDCODE and make IDCODE the reset instruction. Without it IDCODE_OP
// decodes as BYPASS and the reset instruction is BYPASS.
// Ports:
//   CK, TRST          clock and synchronous active-high reset
//   TMS, TDI, TDO     JTAG pins; TDO is 0 outside SHIFT_IR / SHIFT_DR
//   chain_tdi         TDI fanned out to all chains
//   chain_tdo         serial outputs of the external chains
//   chain_sel         one-hot chain picked by the current instruction
//   chain_capture/shift/update  chain_sel qualified by CAPTURE_DR/SHIFT_DR/UPDATE_DR
//   tap_state         current TAP state for debug
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          NUM_CHAINS = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
  parameter int          IDCODE_OP  = 2**IR_WIDTH - 2
) (
  input  logic                  CK,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  chain_tdi,
  input  logic [NUM_CHAINS-1:0] chain_tdo,
  output logic [NUM_CHAINS-1:0] chain_sel,
  output logic [NUM_CHAINS-1:0] chain_capture,
  output logic [NUM_CHAINS-1:0] chain_shift,
  output logic [NUM_CHAINS-1:0] chain_update,
  output logic [3:0]            tap_state
);

  // Elaboration-time parameter sanity checks.
  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("jtag_tap_param: IR_WIDTH must be at least 2");
  end
  if (NUM_CHAINS < 1 || NUM_CHAINS > 2**IR_WIDTH - 3) begin : g_bad_num_chains
    $error("jtag_tap_param: NUM_CHAINS must be in 1..2**IR_WIDTH-3");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("jtag_tap_param: IDCODE_VAL bit 0 must be 1");
  end

  localparam logic [IR_WIDTH-1:0] IDCODE_OPC  = IR_WIDTH'(IDCODE_OP);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(IR_CAPTURE_LSBS);
  localparam logic [IR_WIDTH-1:0] BYPASS_OPC  = '1;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = IDCODE_OPC;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = BYPASS_OPC;
`endif

  tap_state_t          st;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_latch;
  logic [IR_WIDTH-1:0] ir_eff;
  logic                bypass_q;
  dec_t                dec;
  logic                dr_bit;

  jtag_tap_fsm u_fsm (
    .CK        (CK),
    .TRST      (TRST),
    .TMS       (TMS),
    .tap_state (st)
  );

  assign tap_state = st;
  assign chain_tdi = TDI;

  // Instruction register and bypass register.
  always_ff @(posedge CK) begin
    if (TRST) begin
      ir_sr    <= IR_CAPTURE;
      ir_latch <= RESET_INSTR;
      bypass_q <= 1'b0;
    end else begin
      case (st)
        TEST_LOGIC_RESET: ir_latch <= RESET_INSTR;
        CAPTURE_IR:       ir_sr    <= IR_CAPTURE;
        SHIFT_IR:         ir_sr    <= {TDI, ir_sr[IR_WIDTH-1:1]};
        UPDATE_IR:        ir_latch <= ir_sr;
        CAPTURE_DR:       bypass_q <= 1'b0;
        SHIFT_DR:         bypass_q <= TDI;
        default:          ;
      endcase
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_sr;

  always_ff @(posedge CK) begin
    if (TRST) begin
      idcode_sr <= IDCODE_VAL;
    end else if (st == CAPTURE_DR) begin
      idcode_sr <= IDCODE_VAL;
    end else if (st == SHIFT_DR) begin
      idcode_sr <= {TDI, idcode_sr[31:1]};
    end
  end
`endif

  // On entry to TEST_LOGIC_RESET via TMS the latch still holds the old opcode
  // for one cycle; decoding the reset instruction while in that state makes the
  // chain outputs drop immediately instead of one cycle late.
  assign ir_eff = (st == TEST_LOGIC_RESET) ? RESET_INSTR : ir_latch;

  always_comb begin
    dec       = DEC_BYPASS;
    chain_sel = '0;
    if (ir_eff == '0 || ir_eff == BYPASS_OPC) begin
      dec = DEC_BYPASS;
    end else if (ir_eff == IDCODE_OPC) begin
`ifdef JTAG_IDCODE_EN
      dec = DEC_IDCODE;
`else
      dec = DEC_BYPASS;
`endif
    end else begin
      for (int k = 0; k < NUM_CHAINS; k++) begin
        if (ir_eff == IR_WIDTH'(k + 1)) begin
          dec          = DEC_CHAIN;
          chain_sel[k] = 1'b1;
        end
      end
    end
  end

  assign chain_capture = chain_sel & {NUM_CHAINS{st == CAPTURE_DR}};
  assign chain_shift   = chain_sel & {NUM_CHAINS{st == SHIFT_DR}};
  assign chain_update  = chain_sel & {NUM_CHAINS{st == UPDATE_DR}};

  // Serial bit of whichever data register the instruction selects.
  always_comb begin
    dr_bit = bypass_q;
    case (dec)
`ifdef JTAG_IDCODE_EN
      DEC_IDCODE: dr_bit = idcode_sr[0];
`endif
      DEC_CHAIN:  dr_bit = |(chain_sel & chain_tdo);
      default:    dr_bit = bypass_q;
    endcase
  end

  always_comb begin
    TDO = 1'b0;
    if (st == SHIFT_IR) begin
      TDO = ir_sr[0];
    end else if (st == SHIFT_DR) begin
      TDO = dr_bit;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
module tb_jtag_tap_param;
  import jtag_pkg::*;

`ifdef JTAG_IDCODE_EN
  localparam bit IDC = 1'b1;
`else
  localparam bit IDC = 1'b0;
`endif
  localparam logic [31:0] IDV = 32'h1234_5677;

  logic       CK;
  logic       TRST;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       chain_tdi;
  logic [1:0] chain_tdo;
  logic [1:0] chain_sel;
  logic [1:0] chain_capture;
  logic [1:0] chain_shift;
  logic [1:0] chain_update;
  logic [3:0] tap_state;

  int n_vec;
  int n_err;

  jtag_tap_param #(
    .IR_WIDTH   (4),
    .NUM_CHAINS (2),
    .IDCODE_VAL (IDV)
  ) dut (
    .CK            (CK),
    .TRST          (TRST),
    .TMS           (TMS),
    .TDI           (TDI),
    .TDO           (TDO),
    .chain_tdi     (chain_tdi),
    .chain_tdo     (chain_tdo),
    .chain_sel     (chain_sel),
    .chain_capture (chain_capture),
    .chain_shift   (chain_shift),
    .chain_update  (chain_update),
    .tap_state     (tap_state)
  );

  // Clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are looked at 1ns
  // after the rising edge.
  task automatic tick(input logic tms, input logic tdi);
    @(negedge CK);
    TMS = tms;
    TDI = tdi;
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CK);
    TRST = 1'b1;
    TMS  = 1'b0;
    @(posedge CK);
    #1;
    TRST = 1'b0;
  endtask

  // From RUN_TEST_IDLE to SHIFT_DR
  task automatic goto_shift_dr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RUN_TEST_IDLE: load op into the IR, return to RUN_TEST_IDLE
  task automatic load_ir(input logic [3:0] op);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp_w;
    logic [31:0] pat;
    n_vec     = 0;
    n_err     = 0;
    TRST      = 1'b1;
    TMS       = 1'b1;
    TDI       = 1'b0;
    chain_tdo = 2'b00;

    // State walk: {tms, tdi, state after edge, TDO after edge}
    tbl[0]  = '{1'b0, 1'b1, 4'hC, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'h7, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h6, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'h1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h3, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h3, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h2, IDC};
    tbl[8]  = '{1'b0, 1'b1, 4'h2, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 4'h1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'h5, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'h7, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 4'h4, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'hE, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 4'h9, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'hB, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 4'h8, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'hA, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 4'h9, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 4'hD, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 4'hC, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 4'h7, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 4'h4, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 4'hF, 1'b0};
    tbl[24] = '{1'b1, 1'b1, 4'hF, 1'b0};

    // Reset state
    do_reset();
    check("rst_state", tap_state, 4'hF);
    check("rst_sel", chain_sel, 2'b00);
    check("rst_tdo", TDO, 1'b0);
    check("rst_strobes", {chain_capture, chain_shift, chain_update}, 6'b0);

    // Table-driven walk through the TAP graph
    for (int i = 0; i < 25; i++) begin
      tick(tbl[i].tms, tbl[i].tdi);
      check($sformatf("walk_state[%0d]", i), tap_state, tbl[i].st);
      check($sformatf("walk_tdo[%0d]", i), TDO, tbl[i].tdo);
    end

    // DR read after reset: IDCODE LSB first, or 1-bit bypass echoing TDI
    pat = 32'hA5C3_0F96;
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("dr_read_state", tap_state, 4'h2);
    got = '0;
    for (int i = 0; i < 32; i++) begin
      got[i] = TDO;
      tick(i == 31, pat[i]);
    end
    exp_w = IDC ? IDV : {pat[30:0], 1'b0};
    check("dr_read_word", got, exp_w);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("dr_read_rti", tap_state, 4'hC);

    // Reset via TMS from SHIFT_DR, chain selected beforehand
    load_ir(4'h1);
    check("tms_rst_presel", chain_sel, 2'b01);
    goto_shift_dr();
    check("tms_rst_shift", tap_state, 4'h2);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check("tms_rst_4", tap_state, 4'h4);
    tick(1'b1, 1'b0);
    check("tms_rst_5", tap_state, 4'hF);
    check("tms_rst_sel", chain_sel, 2'b00);
    tick(1'b1, 1'b0);
    check("tms_rst_6", tap_state, 4'hF);
    check("tms_rst_sel6", chain_sel, 2'b00);

    // IR capture pattern, then BYPASS via opcode F
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("ir_shift_state", tap_state, 4'hA);
    got = '0;
    for (int i = 0; i < 4; i++) begin
      got[i] = TDO;
      tick(i == 3, 1'b1);
    end
    check("ir_capture_bits", got, 32'h1);
    tick(1'b1, 1'b0);
    check("ir_update_state", tap_state, 4'hD);
    tick(1'b0, 1'b0);
    check("byp_sel", chain_sel, 2'b00);
    goto_shift_dr();
    check("byp_tdo0", TDO, 1'b0);
    tick(1'b0, 1'b1);
    check("byp_tdo1", TDO, 1'b1);
    tick(1'b0, 1'b0);
    check("byp_tdo2", TDO, 1'b0);
    tick(1'b0, 1'b1);
    check("byp_tdo3", TDO, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // Chain 1 via opcode 2
    load_ir(4'h2);
    check("ch_sel", chain_sel, 2'b10);
    tick(1'b1, 1'b0);
    check("ch_cap_sel_dr", chain_capture, 2'b00);
    tick(1'b0, 1'b0);
    check("ch_cap", chain_capture, 2'b10);
    check("ch_cap_noshift", chain_shift, 2'b00);
    tick(1'b0, 1'b0);
    check("ch_shift", chain_shift, 2'b10);
    check("ch_cap_done", chain_capture, 2'b00);
    chain_tdo = 2'b10;
    #1;
    check("ch_tdo_hi", TDO, 1'b1);
    chain_tdo = 2'b01;
    #1;
    check("ch_tdo_lo", TDO, 1'b0);
    TDI = 1'b1;
    #1;
    check("ch_tdi", chain_tdi, 1'b1);
    tick(1'b1, 1'b0);
    check("ch_exit_shift", chain_shift, 2'b00);
    check("ch_exit_upd", chain_update, 2'b00);
    tick(1'b1, 1'b0);
    check("ch_upd", chain_update, 2'b10);
    check("ch_upd_sel", chain_sel, 2'b10);
    tick(1'b0, 1'b0);
    check("ch_upd_done", chain_update, 2'b00);

    // Chain 0 via opcode 1
    load_ir(4'h1);
    check("ch0_sel", chain_sel, 2'b01);
    goto_shift_dr();
    check("ch0_shift", chain_shift, 2'b01);
    check("ch0_tdo", TDO, 1'b1);
    chain_tdo = 2'b00;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // Illegal opcode 7 decodes to BYPASS
    load_ir(4'h7);
    check("ill_sel", chain_sel, 2'b00);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("ill_cap", chain_capture, 2'b00);
    tick(1'b0, 1'b0);
    check("ill_tdo0", TDO, 1'b0);
    tick(1'b0, 1'b1);
    check("ill_tdo1", TDO, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // TRST during the 10th DR shift
    load_ir(4'h2);
    goto_shift_dr();
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
    do_reset();
    check("trst_state", tap_state, 4'hF);
    check("trst_tdo", TDO, 1'b0);
    check("trst_sel", chain_sel, 2'b00);
    tick(1'b0, 1'b0);
    goto_shift_dr();
    check("trst_dr0", TDO, IDC);
    tick(1'b0, 1'b1);
    check("trst_dr1", TDO, 1'b1);
    tick(1'b0, 1'b0);
    check("trst_dr2", TDO, IDC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
